pc_exception_ctrl: RTL
======================

Name: pc_exception_ctrl

Overview:
- Parametrised program-counter and exception unit for the multicycle MIPS datapath. Holds the PC, ALUOut and EPC registers and selects the next PC among ALU result, ALUOut, jump target and EPC.
- Adds a hardware exception sequencer. It prioritises N cause requests, saves the EPC, fetches the handler byte from the vector table in memory over a req/ack handshake, and loads it into the PC.
- Sits between the control unit, the ALU and the memory port.

Parameters:
- DATA_W, 32: width of PC, EPC, ALUOut and data inputs (≥ 8).
- NUM_CAUSES, 3: number of exception sources (1..8).
- CAUSE_W, 2: cause code width, ≥ clog2(NUM_CAUSES), minimum 1.
- VEC_BASE, 253: vector-table byte address of cause 0. Cause i is read at VEC_BASE+i.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc_write  in  1  normal PC update enable.
- pc_source  in  2  next-PC select: 0 alu_result, 1 aluout, 2 jump target, 3 epc.
- aluout_write  in  1  ALUOut register load enable.
- alu_result  in  DATA_W  combinational ALU result.
- instr_index  in  26  jump field.
- epc_in  in  DATA_W  faulting-instruction address to save.
- exc_req  in  NUM_CAUSES  exception requests; bit 0 has highest priority.
- mem_req  out  1  vector fetch request.
- mem_addr  out  DATA_W  vector byte address.
- mem_ack  in  1  fetch complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  handler address byte.
- pc  out  DATA_W  program counter.
- aluout  out  DATA_W  ALUOut register.
- epc  out  DATA_W  EPC register.
- cause  out  CAUSE_W  latched cause code.
- exc_busy  out  1  high while the sequencer is not IDLE.
- exc_done  out  1  one-cycle pulse when the handler PC is loaded.

Behaviour:
- Reset values: pc = RESET_PC; aluout = 0; epc = 0; cause = 0; mem_req = 0; mem_addr = 0; exc_busy = 0; exc_done = 0; state = IDLE. Reset wins over every other input.
- Jump target = {pc[DATA_W-1:DATA_W-4], instr_index, 2'b00}. For DATA_W < 32, take the low DATA_W bits of this concatenation.
- The ALUOut register loads alu_result whenever aluout_write = 1, in every state.
- States: IDLE, FETCH, COMMIT.
- IDLE with exc_req ≠ 0:
  - At the edge, cause ← index of the lowest set bit, epc ← epc_in, state ← FETCH.
  - pc_write is ignored that cycle: an exception beats a normal update, including pc_source = 3.
- IDLE with exc_req = 0 and pc_write = 1: pc ← the selected source at the edge. No latency; the new value is visible the next cycle.
- FETCH:
  - mem_req = 1 and mem_addr = VEC_BASE + cause, both registered outputs, asserted from the first FETCH cycle.
  - Held stable until mem_ack. Waits indefinitely.
  - On mem_ack, the byte is captured, mem_req drops at the edge, and state ← COMMIT.
  - mem_ack outside FETCH is ignored.
- COMMIT: pc ← zero-extended captured byte, exc_done = 1 for this one cycle, state ← IDLE.
- exc_busy = 1 in FETCH and COMMIT.
- While exc_busy = 1:
  - pc_write is ignored.
  - exc_req is not sampled. Requesters hold their requests; a request still asserted on return to IDLE is taken then, giving back-to-back exceptions.
- Minimum exception latency is 3 edges: detect→FETCH, ack→COMMIT, COMMIT→IDLE with pc loaded at the COMMIT edge.
- Return from exception: pc_source = 3 with pc_write in IDLE loads epc.
- epc and cause change only on exception entry.
- Reset asserted in FETCH or COMMIT aborts the sequence. Next cycle: state IDLE, mem_req 0, registers at reset values, no exc_done pulse.

Test Plan:
- Reset: hold reset 2 cycles → pc = 0, epc = 0, mem_req = 0, exc_busy = 0.
- Normal update: alu_result = 0x00000004, pc_source = 0, pc_write = 1 → pc = 0x00000004 next cycle. Then pc = 0x40000000, instr_index = 0x0000010, pc_source = 2 → pc = 0x40000040.
- Priority and fetch:
  - Stimulus: exc_req = 3'b110, epc_in = 0x00000020, pc_write = 1 in the same cycle.
  - Required: cause = 1 and epc = 0x20; pc unchanged; mem_req = 1 with mem_addr = 254.
  - Then mem_ack after 3 wait cycles with mem_rdata = 0x80 → pc = 0x00000080, exc_done pulses once, exc_busy falls.
- Busy masking: during FETCH assert pc_write and exc_req = 3'b001 → pc and cause unchanged. exc_req still held in IDLE → new entry with cause = 0, mem_addr = 253.
- Return: in IDLE with epc = 0x20, pc_source = 3, pc_write = 1 → pc = 0x00000020.
- Reset mid-fetch: reset asserted while mem_req = 1 → next cycle mem_req = 0, state IDLE, pc = 0, no exc_done.

Source files
------------

// File: rtl/pc_exception_ctrl_if.sv
// Vector-fetch memory port of the PC/exception unit.
//   mem_req   : vector fetch request (driven by the exception unit)
//   mem_addr  : vector table byte address (driven by the exception unit)
//   mem_ack   : fetch complete, mem_rdata valid in the same cycle (driven by memory)
//   mem_rdata : handler address byte (driven by memory)
interface pc_exception_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/pc_exception_ctrl.sv
// Program-counter and exception unit for the multicycle MIPS datapath.
// Holds PC, ALUOut and EPC, selects the next PC (ALU result, ALUOut, jump
// target, EPC) and runs a small exception sequencer that prioritises the
// cause requests, saves EPC, fetches the handler byte from the vector table
// and loads it into the PC.
// Ports:
//   clk, reset    : clock (rising edge), synchronous active-high reset
//   pc_write      : normal PC update enable (ignored while busy / on exception)
//   pc_source     : 0 alu_result, 1 aluout, 2 jump target, 3 epc
//   aluout_write  : ALUOut load enable, honoured in every state
//   alu_result    : combinational ALU result
//   instr_index   : 26-bit jump field
//   epc_in        : faulting instruction address saved on exception entry
//   exc_req       : exception requests, bit 0 highest priority
//   mem           : vector fetch port (req/addr out, ack/rdata in)
//   pc, aluout, epc, cause : architectural registers
//   exc_busy      : sequencer not idle
//   exc_done      : high for the single COMMIT cycle (handler PC loaded at its edge)
module pc_exception_ctrl #(
  parameter int DATA_W     = 32,
  parameter int NUM_CAUSES = 3,
  parameter int CAUSE_W    = 2,
  parameter int VEC_BASE   = 253,
  parameter int RESET_PC   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_write,
  input  logic [1:0]             pc_source,
  input  logic                   aluout_write,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [25:0]            instr_index,
  input  logic [DATA_W-1:0]      epc_in,
  input  logic [NUM_CAUSES-1:0]  exc_req,
  pc_exception_ctrl_if.master    mem,
  output logic [DATA_W-1:0]      pc,
  output logic [DATA_W-1:0]      aluout,
  output logic [DATA_W-1:0]      epc,
  output logic [CAUSE_W-1:0]     cause,
  output logic                   exc_busy,
  output logic                   exc_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]         state;
  logic [7:0]         vec_byte;
  logic [31:0]        jt_full;
  logic [DATA_W-1:0]  jump_target;
  logic [DATA_W-1:0]  pc_next;
  logic [CAUSE_W-1:0] cause_next;
  logic               exc_any;

  // The concatenation is 32 bits wide; narrower datapaths keep the low bits.
  assign jt_full     = {pc[DATA_W-1 -: 4], instr_index, 2'b00};
  assign jump_target = DATA_W'(jt_full);

  always_comb begin
    pc_next = alu_result;
    unique case (pc_source)
      2'd0: pc_next = alu_result;
      2'd1: pc_next = aluout;
      2'd2: pc_next = jump_target;
      2'd3: pc_next = epc;
    endcase
  end

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    cause_next = '0;
    for (int unsigned i = NUM_CAUSES; i > 0; i--) begin
      if (exc_req[i-1]) cause_next = CAUSE_W'(i - 1);
    end
  end

  assign exc_any  = |exc_req;
  assign exc_busy = (state != IDLE);
  assign exc_done = (state == COMMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= DATA_W'(RESET_PC);
      aluout       <= '0;
      epc          <= '0;
      cause        <= '0;
      vec_byte     <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      if (aluout_write) aluout <= alu_result;

      unique case (state)
        IDLE: begin
          if (exc_any) begin
            cause        <= cause_next;
            epc          <= epc_in;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= DATA_W'(VEC_BASE) + DATA_W'(cause_next);
            state        <= FETCH;
          end else if (pc_write) begin
            pc <= pc_next;
          end
        end
        FETCH: begin
          if (mem.mem_ack) begin
            vec_byte    <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            state       <= COMMIT;
          end
        end
        COMMIT: begin
          pc    <= DATA_W'(vec_byte);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
